serial_adder_ctrl: RTL

Bit-serial add/subtract sequencer that time-shares one external single-bit full adder cell across a WIDTH-bit operation. It latches two 2's-complement operands on a start handshake and presents one bit pair plus the running carry to the adder per clock. It collects sum bits LSB-first and reports sum, carryout and overflow with a one-cycle done pulse. It replaces a WIDTH-wide ripple adder where area matters more than latency.

---
 rtl/serial_adder_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer that time-shares one external full adder cell.
// Operands are latched on start, fed to the cell LSB-first and the result is reported with a done pulse.
module serial_adder_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             subtract,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_carryin,
   input  logic             fa_sum,
   input  logic             fa_carryout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carryout,
   output logic             overflow
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_reg, b_reg;
   logic             carry;
   logic [IW-1:0]    idx;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (idx == LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

   // The adder cell sees zeros whenever no operation is in flight.
   assign fa_a       = busy & a_reg[idx];
   assign fa_b       = busy & b_reg[idx];
   assign fa_carryin = busy & carry;

   always_ff @(posedge clk) begin
      if (reset) begin
         a_reg    <= '0;
         b_reg    <= '0;
         carry    <= 1'b0;
         idx      <= '0;
         sum      <= '0;
         carryout <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               // Subtraction is a + ~b + 1: invert b and seed the carry.
               a_reg    <= a;
               b_reg    <= subtract ? ~b : b;
               carry    <= subtract;
               idx      <= '0;
               sum      <= '0;
               carryout <= 1'b0;
               overflow <= 1'b0;
            end
            RUN: begin
               sum[idx] <= fa_sum;
               carry    <= fa_carryout;
               idx      <= idx + 1'b1;
               if (idx == LAST) begin
                  carryout <= fa_carryout;
                  overflow <= carry ^ fa_carryout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
